dual_issue_buffer: RTL and testbench

//  Instruction buffer between fetch and the EX1 issue register of the dual-issue core.

---
 rtl/dual_issue_buffer_if.sv | 28 ++
 rtl/dual_issue_buffer.sv | 118 +++++++++++
 tb/tb_dual_issue_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_issue_buffer_if.sv
// Fetch-side and issue-side signals of the dual-issue instruction buffer.
// The buffer takes the slave modport; fetch and the hazard unit drive the master side.
interface dual_issue_buffer_if #(
  parameter int XLEN = 32
);
  logic [1:0]      fetch_valid;
  logic [XLEN-1:0] fetch_instr0;
  logic [XLEN-1:0] fetch_instr1;
  logic [XLEN-1:0] fetch_pc0;
  logic [XLEN-1:0] fetch_pc1;
  logic            fetch_ready;
  logic            stall;
  logic [1:0]      issue_valid;
  logic [XLEN-1:0] issue_instr1;
  logic [XLEN-1:0] issue_instr2;
  logic [XLEN-1:0] issue_pc1;
  logic [XLEN-1:0] issue_pc2;

  modport master (
    output fetch_valid, fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1, stall,
    input  fetch_ready, issue_valid, issue_instr1, issue_instr2, issue_pc1, issue_pc2
  );

  modport slave (
    input  fetch_valid, fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1, stall,
    output fetch_ready, issue_valid, issue_instr1, issue_instr2, issue_pc1, issue_pc2
  );
endinterface

// File: rtl/dual_issue_buffer.sv
// Circular instruction buffer between fetch and EX1 issue: 0-2 pushes and 0-2 pops per cycle.
// Optional macro ISSUE_BUF_STATS_EN adds saturating single-issue and stall cycle counters.
module dual_issue_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  dual_issue_buffer_if.slave   bus
`ifdef ISSUE_BUF_STATS_EN
  ,
  output logic [31:0]          stat_single_cnt,
  output logic [31:0]          stat_stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_nxt, wr_nxt;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] head_instr, next_instr;
  logic            has1, has2, dep, ctrl1, fetch_ready, push0, push1;
  logic [1:0]      issue_valid, push_n, pop_n;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    rd_nxt      = rd_ptr_q + PW'(1);
    wr_nxt      = wr_ptr_q + PW'(1);
    head_instr  = instr_mem_q[rd_ptr_q];
    next_instr  = instr_mem_q[rd_nxt];
    has1        = (count_q != '0);
    has2        = (count_q >= CW'(2));
    // Instr2 waits if it reads instr1's destination or instr1 redirects the PC.
    dep         = (head_instr[11:7] != 5'd0) &&
                  ((head_instr[11:7] == next_instr[19:15]) ||
                   (head_instr[11:7] == next_instr[24:20]));
    ctrl1       = head_instr[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
    issue_valid = {has2 && !dep && !ctrl1, has1};
    fetch_ready = (count_q <= READY_MAX);
    // fetch_valid=2'b10 pushes nothing.
    push0       = fetch_ready && !flush && bus.fetch_valid[0];
    push1       = fetch_ready && !flush && (bus.fetch_valid == 2'b11);
    push_n      = {1'b0, push0} + {1'b0, push1};
    pop_n       = bus.stall ? 2'b00 : ({1'b0, issue_valid[0]} + {1'b0, issue_valid[1]});
    rd_ptr_d    = rd_ptr_q + PW'(pop_n);
    wr_ptr_d    = wr_ptr_q + PW'(push_n);
    count_d     = count_q + CW'(push_n) - CW'(pop_n);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which slots hold live entries.
  always_ff @(posedge clk) begin
    if (push0) begin
      instr_mem_q[wr_ptr_q] <= bus.fetch_instr0;
      pc_mem_q[wr_ptr_q]    <= bus.fetch_pc0;
    end
    if (push1) begin
      instr_mem_q[wr_nxt] <= bus.fetch_instr1;
      pc_mem_q[wr_nxt]    <= bus.fetch_pc1;
    end
  end

  assign bus.fetch_ready  = fetch_ready;
  assign bus.issue_valid  = issue_valid;
  assign bus.issue_instr1 = has1 ? head_instr : '0;
  assign bus.issue_pc1    = has1 ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.issue_instr2 = issue_valid[1] ? next_instr : '0;
  assign bus.issue_pc2    = issue_valid[1] ? pc_mem_q[rd_nxt] : '0;

`ifdef ISSUE_BUF_STATS_EN
  logic [31:0] stat_single_q, stat_single_d, stat_stall_q, stat_stall_d;

  // Flush does not clear these; only reset does.
  always_comb begin
    stat_single_d = stat_single_q;
    stat_stall_d  = stat_stall_q;
    if (has2 && !bus.stall && (issue_valid == 2'b01) && (stat_single_q != '1))
      stat_single_d = stat_single_q + 32'd1;
    if (bus.stall && (issue_valid != 2'b00) && (stat_stall_q != '1))
      stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_single_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_single_q <= stat_single_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_single_cnt = stat_single_q;
  assign stat_stall_cnt  = stat_stall_q;
`endif
endmodule

// File: tb/tb_dual_issue_buffer.sv
// Self-checking bench for dual_issue_buffer: directed table, corner sequences and random traffic
// compared each cycle against a queue-based model of the buffer.
module tb_dual_issue_buffer;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  typedef struct {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef struct {
    logic [1:0]  fv;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        stall;
    logic [1:0]  exp_valid;
    logic        exp_ready;
  } vec_t;

  logic clk, rstn, flush;
  dual_issue_buffer_if #(.XLEN(XLEN)) bus ();
`ifdef ISSUE_BUF_STATS_EN
  logic [31:0] stat_single_cnt, stat_stall_cnt;
`endif

  dual_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
`ifdef ISSUE_BUF_STATS_EN
    ,
    .stat_single_cnt (stat_single_cnt),
    .stat_stall_cnt  (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  entry_t      q[$];
  logic [31:0] m_single = 0;
  logic [31:0] m_stall  = 0;
  logic [31:0] pc_ctr   = 32'h100;

  localparam logic [31:0] ADDI_X1 = 32'h00100093;
  localparam logic [31:0] ADDI_X2 = 32'h00200113;
  localparam logic [31:0] ADDI_X5 = 32'h00100293;
  localparam logic [31:0] ADD_X6  = 32'h00528333;
  localparam logic [31:0] BEQ     = 32'h00208463;
  localparam logic [31:0] ADDI_X3 = 32'h00300193;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // addi xN, x0, 0: reads nothing but x0, so any pair of these may dual-issue.
  function automatic logic [31:0] indep(input int n);
    return (32'(n % 31 + 1) << 7) | 32'h13;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    case ($urandom_range(0, 4))
      0:       opc = 7'b1100011;
      1:       opc = 7'b1101111;
      2:       opc = 7'b1100111;
      3:       opc = 7'b0110011;
      default: opc = 7'b0010011;
    endcase
    return {7'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b0,
            5'($urandom_range(0, 3)), opc};
  endfunction

  // Instr2 may go with instr1 unless it reads instr1's destination or instr1 is a control op.
  function automatic bit pair_ok(input logic [31:0] a, input logic [31:0] b);
    logic [4:0] rd;
    bit hazard, ctrl;
    rd     = a[11:7];
    hazard = (rd != 0) && (rd == b[19:15] || rd == b[24:20]);
    ctrl   = (a[6:0] == 7'b1100011) || (a[6:0] == 7'b1101111) || (a[6:0] == 7'b1100111);
    return !hazard && !ctrl;
  endfunction

  function automatic logic [1:0] m_valid();
    logic [1:0] v;
    v[0] = (q.size() >= 1);
    v[1] = (q.size() >= 2) && pair_ok(q[0].instr, q[1].instr);
    return v;
  endfunction

  task automatic compare_all();
    logic [1:0] v;
    v = m_valid();
    check("issue_valid", 64'(bus.issue_valid), 64'(v));
    check("fetch_ready", 64'(bus.fetch_ready), 64'(DEPTH - q.size() >= 2));
    check("issue_instr1", 64'(bus.issue_instr1), v[0] ? 64'(q[0].instr) : 64'd0);
    check("issue_pc1", 64'(bus.issue_pc1), v[0] ? 64'(q[0].pc) : 64'd0);
    check("issue_instr2", 64'(bus.issue_instr2), v[1] ? 64'(q[1].instr) : 64'd0);
    if (v[1]) check("issue_pc2", 64'(bus.issue_pc2), 64'(q[1].pc));
`ifdef ISSUE_BUF_STATS_EN
    check("stat_single_cnt", 64'(stat_single_cnt), 64'(m_single));
    check("stat_stall_cnt", 64'(stat_stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic model_edge(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                            input logic [31:0] p0, input logic [31:0] p1,
                            input logic st, input logic fl, input logic rn);
    logic [1:0] v;
    int sz, npop;
    bit ready;
    v  = m_valid();
    sz = q.size();
    if (!rn) begin
      m_single = 0;
      m_stall  = 0;
    end else begin
      if (sz >= 2 && !st && v == 2'b01 && m_single != '1) m_single++;
      if (st && v != 2'b00 && m_stall != '1) m_stall++;
    end
    if (!rn || fl) begin
      q.delete();
      return;
    end
    ready = (DEPTH - sz >= 2);
    npop  = st ? 0 : int'(v[0]) + int'(v[1]);
    for (int k = 0; k < npop; k++) void'(q.pop_front());
    if (ready && fv[0]) q.push_back('{i0, p0});
    if (ready && fv == 2'b11) q.push_back('{i1, p1});
  endtask

  // One clock cycle: drive, compare mid-cycle, clock the model with the same inputs.
  task automatic step(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic st, input logic fl, input logic rn, output logic [1:0] seen);
    bus.fetch_valid  = fv;
    bus.fetch_instr0 = i0;
    bus.fetch_instr1 = i1;
    bus.fetch_pc0    = pc_ctr;
    bus.fetch_pc1    = pc_ctr + 32'd4;
    bus.stall        = st;
    flush            = fl;
    rstn             = rn;
    #4;
    compare_all();
    seen = bus.issue_valid;
    @(posedge clk);
    model_edge(fv, i0, i1, pc_ctr, pc_ctr + 32'd4, st, fl, rn);
    pc_ctr = pc_ctr + 32'd8;
    #1;
  endtask

  task automatic drain(output int n);
    logic [1:0] seen;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      step(2'b00, 0, 0, 1'b0, 1'b0, 1'b1, seen);
      n += int'(seen[0]) + int'(seen[1]);
      if (seen == 2'b00) break;
    end
  endtask

  vec_t vecs[11];

  initial begin
    logic [1:0] seen;
    int n;
    logic [31:0] s0;

    vecs[0]  = '{2'b11, ADDI_X1, ADDI_X2, 1'b0, 2'b00, 1'b1};
    vecs[1]  = '{2'b00, 0, 0, 1'b0, 2'b11, 1'b1};
    vecs[2]  = '{2'b00, 0, 0, 1'b0, 2'b00, 1'b1};
    vecs[3]  = '{2'b11, ADDI_X5, ADD_X6, 1'b0, 2'b00, 1'b1};
    vecs[4]  = '{2'b00, 0, 0, 1'b0, 2'b01, 1'b1};
    vecs[5]  = '{2'b00, 0, 0, 1'b0, 2'b01, 1'b1};
    vecs[6]  = '{2'b10, ADDI_X1, ADDI_X2, 1'b0, 2'b00, 1'b1};
    vecs[7]  = '{2'b11, BEQ, ADDI_X3, 1'b0, 2'b00, 1'b1};
    vecs[8]  = '{2'b00, 0, 0, 1'b0, 2'b01, 1'b1};
    vecs[9]  = '{2'b00, 0, 0, 1'b0, 2'b01, 1'b1};
    vecs[10] = '{2'b00, 0, 0, 1'b0, 2'b00, 1'b1};

    rstn = 1'b0;
    flush = 1'b0;
    bus.fetch_valid = 2'b00;
    bus.fetch_instr0 = 0;
    bus.fetch_instr1 = 0;
    bus.fetch_pc0 = 0;
    bus.fetch_pc1 = 0;
    bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #3;
    check("reset issue_valid", 64'(bus.issue_valid), 64'd0);
    check("reset fetch_ready", 64'(bus.fetch_ready), 64'd1);
    check("reset issue_instr1", 64'(bus.issue_instr1), 64'd0);
    check("reset issue_pc1", 64'(bus.issue_pc1), 64'd0);
    @(posedge clk);
    #1;

    // Directed table: basic pair, dependency hold-back, ignored 2'b10, control hold-back.
    for (int i = 0; i < 11; i++) begin
`ifdef ISSUE_BUF_STATS_EN
      s0 = stat_single_cnt;
`else
      s0 = 0;
`endif
      step(vecs[i].fv, vecs[i].i0, vecs[i].i1, vecs[i].stall, 1'b0, 1'b1, seen);
      check($sformatf("vec%0d issue_valid", i), 64'(seen), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d fetch_ready", i), 64'(bus.fetch_ready), 64'(vecs[i].exp_ready));
`ifdef ISSUE_BUF_STATS_EN
      if (i == 8) check("beq single-issue stat", 64'(stat_single_cnt), 64'(s0 + 32'd1));
`endif
    end

    // Stalled pushes: fetch_ready must fall once 4 pairs are held; head pair stays put.
    for (int k = 0; k < 6; k++) begin
      step(2'b11, indep(2 * k), indep(2 * k + 1), 1'b1, 1'b0, 1'b1, seen);
      check($sformatf("stall fill %0d ready", k), 64'(bus.fetch_ready), 64'(k < 3));
      check($sformatf("stall fill %0d head", k), 64'(bus.issue_instr1), 64'(indep(0)));
    end
    drain(n);
    check("stall fill drained entries", 64'(n), 64'd8);

    // Count 7, then push 1 while popping 2: push refused, 5 remain.
    for (int k = 0; k < 3; k++) step(2'b11, indep(2 * k), indep(2 * k + 1), 1'b1, 1'b0, 1'b1, seen);
    step(2'b01, indep(6), 0, 1'b1, 1'b0, 1'b1, seen);
    step(2'b01, indep(9), 0, 1'b0, 1'b0, 1'b1, seen);
    check("count7 pop2 issue_valid", 64'(seen), 64'd3);
    drain(n);
    check("count7 remaining entries", 64'(n), 64'd5);

    // Flush with a simultaneous push at count 6.
    for (int k = 0; k < 3; k++) step(2'b11, indep(2 * k), indep(2 * k + 1), 1'b1, 1'b0, 1'b1, seen);
    step(2'b11, indep(20), indep(21), 1'b0, 1'b1, 1'b1, seen);
    check("flush issue_valid", 64'(bus.issue_valid), 64'd0);
    check("flush fetch_ready", 64'(bus.fetch_ready), 64'd1);

    // Reset while occupied behaves like flush.
    for (int k = 0; k < 2; k++) step(2'b11, indep(2 * k), indep(2 * k + 1), 1'b1, 1'b0, 1'b1, seen);
    step(2'b11, indep(4), indep(5), 1'b0, 1'b0, 1'b0, seen);
    check("midreset issue_valid", 64'(bus.issue_valid), 64'd0);
    check("midreset fetch_ready", 64'(bus.fetch_ready), 64'd1);

    // Random traffic, including wrap-around, 2'b10, flushes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step(2'($urandom_range(0, 3)), rand_instr(), rand_instr(),
           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 199) != 0), seen);
    end
    drain(n);
    check("final drained empty", 64'(bus.issue_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
